// File: rtl/message_receiver_if.sv
// Bundle of the serial receive path: line input toward the receiver and the
// parallel word / status outputs toward the message consumer.
interface message_receiver_if #(
  parameter int DATA_W = 8
);
  logic              serial_in;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              frame_err;
  logic              busy;

  // master: the link/consumer side; slave: the receiver itself
  modport master (output serial_in, input data_out, valid, frame_err, busy);
  modport slave  (input serial_in, output data_out, valid, frame_err, busy);
endinterface

// File: rtl/message_receiver.sv
// Serial message receiver: start-bit detect on an idle-high line, LSB-first
// data sampled at bit centres, stop-bit check, parallel word with pulses.
module message_receiver #(
  parameter int DATA_W        = 8,
  parameter int TICKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  message_receiver_if.slave   bus
);
  localparam int HALF   = TICKS_PER_BIT / 2;
  localparam int TICK_W = (TICKS_PER_BIT > 2) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(HALF - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_reg,   state_next;
  logic [TICK_W-1:0] tick_reg,    tick_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0] shifter_reg, shifter_next;
  logic [DATA_W-1:0] data_reg,    data_next;
  logic              valid_reg,   valid_next;
  logic              err_reg,     err_next;
  logic [DATA_W:0]   shift_cat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      tick_reg    <= '0;
      bit_cnt_reg <= '0;
      shifter_reg <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      bit_cnt_reg <= bit_cnt_next;
      shifter_reg <= shifter_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
    end
  end

  // New bit enters at the MSB so the first (LSB) bit ends up in bit 0.
  assign shift_cat = {bus.serial_in, shifter_reg};

  always_comb begin
    state_next   = state_reg;
    tick_next    = tick_reg;
    bit_cnt_next = bit_cnt_reg;
    shifter_next = shifter_reg;
    data_next    = data_reg;
    valid_next   = 1'b0;
    err_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!bus.serial_in) begin
          state_next = START;
          tick_next  = '0;
        end
      end

      START: begin
        if (tick_reg == TICK_HALF) begin
          tick_next = '0;
          if (!bus.serial_in) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          tick_next = tick_reg + 1'b1;
        end
      end

      DATA: begin
        if (tick_reg == TICK_LAST) begin
          tick_next    = '0;
          shifter_next = shift_cat[DATA_W:1];
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else begin
          tick_next = tick_reg + 1'b1;
        end
      end

      STOP: begin
        if (tick_reg == TICK_LAST) begin
          tick_next  = '0;
          state_next = IDLE;
          if (bus.serial_in) begin
            data_next  = shifter_reg;
            valid_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end else begin
          tick_next = tick_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        tick_next  = '0;
      end
    endcase
  end

  assign bus.data_out  = data_reg;
  assign bus.valid     = valid_reg;
  assign bus.frame_err = err_reg;
  assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_message_receiver.sv
// Self-checking bench for message_receiver: table vectors, hand sequences and
// random line traffic compared against a frame-level reference model.
module tb_message_receiver;
  localparam int DATA_W    = 8;
  localparam int TPB       = 4;
  localparam int HALF      = TPB / 2;
  localparam int FRAME_LEN = HALF + (DATA_W + 1) * TPB;  // start edge to stop-sample edge

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  message_receiver_if #(.DATA_W(DATA_W)) bus ();

  message_receiver #(.DATA_W(DATA_W), .TICKS_PER_BIT(TPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    bit          err;
    logic [7:0]  data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  int total = 0;
  int bad   = 0;

  bit         line[$];
  ev_t        exp_q[$];
  ev_t        obs_q[$];
  bit         exp_busy[$];
  bit         obs_busy[$];
  logic [7:0] model_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic add_ones(input int n);
    for (int i = 0; i < n; i++) line.push_back(1'b1);
  endtask

  // Each bit occupies TPB cycles; with noise only the centre cycle carries the value.
  task automatic add_frame(input logic [7:0] d, input bit stop, input bit noisy);
    bit v;
    for (int k = 0; k < DATA_W + 2; k++) begin
      if (k == 0)               v = 1'b0;
      else if (k == DATA_W + 1) v = stop;
      else                      v = d[k-1];
      for (int o = 0; o < TPB; o++) begin
        if (noisy && o != HALF && !(k == 0 && o == 0))
          line.push_back(1'($urandom_range(0, 1)));
        else
          line.push_back(v);
      end
    end
  endtask

  // Reference: walk the per-cycle line, finding start detections and reading
  // the centre samples at their fixed offsets from the detecting edge.
  task automatic model();
    int n;
    int i;
    logic [7:0] d;
    n = line.size();
    exp_q.delete();
    exp_busy.delete();
    for (int c = 0; c < n; c++) exp_busy.push_back(1'b0);
    i = 0;
    while (i < n) begin
      if (line[i]) begin
        i++;
      end else if (i + HALF >= n) begin
        for (int j = i; j < n; j++) exp_busy[j] = 1'b1;
        i = n;
      end else if (line[i+HALF]) begin
        for (int j = i; j < i + HALF; j++) exp_busy[j] = 1'b1;
        i = i + HALF + 1;
      end else if (i + FRAME_LEN >= n) begin
        for (int j = i; j < n; j++) exp_busy[j] = 1'b1;
        i = n;
      end else begin
        for (int k = 0; k < DATA_W; k++) d[k] = line[i + HALF + TPB * (k + 1)];
        for (int j = i; j < i + FRAME_LEN; j++) exp_busy[j] = 1'b1;
        if (line[i + FRAME_LEN]) model_data = d;
        exp_q.push_back('{cyc: i + FRAME_LEN, err: !line[i + FRAME_LEN], data: model_data});
        i = i + FRAME_LEN + 1;
      end
    end
  endtask

  // Drive one line value per cycle; outputs after edge c are observed at the
  // following negedge.
  task automatic play();
    int n;
    int m;
    int lim;
    model();
    n = line.size();
    obs_q.delete();
    obs_busy.delete();
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      if (c > 0) begin
        obs_busy.push_back(bus.busy);
        check("pulse_exclusive", 32'(bus.valid & bus.frame_err), 32'd0);
        if (bus.valid)     obs_q.push_back('{cyc: c - 1, err: 1'b0, data: bus.data_out});
        if (bus.frame_err) obs_q.push_back('{cyc: c - 1, err: 1'b1, data: bus.data_out});
      end
      if (c < n) bus.serial_in = line[c];
    end
    check("event_count", 32'(obs_q.size()), 32'(exp_q.size()));
    lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int e = 0; e < lim; e++) begin
      check("event_cycle", 32'(obs_q[e].cyc), 32'(exp_q[e].cyc));
      check("event_kind",  32'(obs_q[e].err), 32'(exp_q[e].err));
      check("event_data",  32'(obs_q[e].data), 32'(exp_q[e].data));
      $display("event %0d: cyc=%0d err=%0d data=%02h", e, obs_q[e].cyc, obs_q[e].err, obs_q[e].data);
    end
    m = 0;
    for (int c = 0; c < n; c++) if (obs_busy[c] != exp_busy[c]) m++;
    check("busy_trace_mismatches", 32'(m), 32'd0);
  endtask

  vec_t tbl[6];
  int   nv, ne, bsum;

  initial begin
    tbl[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_data: 8'hA5};
    tbl[1] = '{data: 8'h3C, stop: 1'b0, exp_valid: 0, exp_err: 1, exp_data: 8'hA5};
    tbl[2] = '{data: 8'h01, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_data: 8'h01};
    tbl[3] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_data: 8'hFF};
    tbl[4] = '{data: 8'h00, stop: 1'b0, exp_valid: 0, exp_err: 1, exp_data: 8'hFF};
    tbl[5] = '{data: 8'h80, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_data: 8'h80};

    bus.serial_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data_out",  32'(bus.data_out),  32'd0);
    check("reset_valid",     32'(bus.valid),     32'd0);
    check("reset_frame_err", 32'(bus.frame_err), 32'd0);
    check("reset_busy",      32'(bus.busy),      32'd0);
    rst = 1'b0;
    model_data = 8'h00;

    // Table vectors: each frame starts 2 cycles into its line (e0 = 2).
    for (int t = 0; t < 6; t++) begin
      line.delete();
      add_ones(2);
      add_frame(tbl[t].data, tbl[t].stop, 1'b0);
      add_ones(6);
      play();
      nv = 0; ne = 0;
      foreach (obs_q[e]) if (obs_q[e].err) ne++; else nv++;
      check("tbl_valid_pulses", 32'(nv), 32'(tbl[t].exp_valid));
      check("tbl_err_pulses",   32'(ne), 32'(tbl[t].exp_err));
      check("tbl_data_out",     32'(bus.data_out), 32'(tbl[t].exp_data));
      // edges e0 .. e0+38 inclusive, the last one producing the pulse
      if (obs_q.size() > 0) check("tbl_latency_edges", 32'(obs_q[0].cyc - 2 + 1), 32'd39);
      $display("vector %0d: data=%02h stop=%0d valid=%0d err=%0d data_out=%02h",
               t, tbl[t].data, tbl[t].stop, nv, ne, bus.data_out);
    end

    // Start glitch: one low cycle.
    line.delete();
    add_ones(2);
    line.push_back(1'b0);
    add_ones(8);
    play();
    bsum = 0;
    foreach (obs_busy[c]) bsum += int'(obs_busy[c]);
    check("glitch_busy_cycles", 32'(bsum), 32'd2);
    check("glitch_no_pulses", 32'(obs_q.size()), 32'd0);
    $display("glitch: busy_cycles=%0d pulses=%0d", bsum, obs_q.size());

    // Back-to-back frames without idle gap.
    line.delete();
    add_ones(1);
    add_frame(8'h01, 1'b1, 1'b0);
    add_frame(8'hFF, 1'b1, 1'b0);
    add_ones(45);
    play();
    check("b2b_pulses", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      check("b2b_first_data",  32'(obs_q[0].data), 32'h01);
      check("b2b_second_data", 32'(obs_q[1].data), 32'hFF);
      check("b2b_spacing",     32'(obs_q[1].cyc - obs_q[0].cyc), 32'd40);
    end
    $display("back_to_back: pulses=%0d data_out=%02h", obs_q.size(), bus.data_out);

    // Reset in the middle of bit 4 of frame 0x55.
    line.delete();
    add_frame(8'h55, 1'b1, 1'b0);
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      bus.serial_in = line[c];
    end
    @(negedge clk);
    check("midframe_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.serial_in = 1'b1;
    @(negedge clk);
    check("midrst_data_out",  32'(bus.data_out),  32'd0);
    check("midrst_valid",     32'(bus.valid),     32'd0);
    check("midrst_frame_err", 32'(bus.frame_err), 32'd0);
    check("midrst_busy",      32'(bus.busy),      32'd0);
    $display("mid_frame_reset: data_out=%02h busy=%0d", bus.data_out, bus.busy);
    rst = 1'b0;
    model_data = 8'h00;
    line.delete();
    add_ones(2);
    add_frame(8'h12, 1'b1, 1'b0);
    add_ones(6);
    play();
    check("after_rst_pulses", 32'(obs_q.size()), 32'd1);
    check("after_rst_data",   32'(bus.data_out), 32'h12);
    $display("after_reset frame: data_out=%02h", bus.data_out);

    // Break: line held low, then released.
    line.delete();
    add_ones(1);
    for (int c = 0; c < 100; c++) line.push_back(1'b0);
    add_ones(50);
    play();
    if (obs_q.size() > 0) check("break_first_is_err", 32'(obs_q[0].err), 32'd1);
    $display("break: pulses=%0d", obs_q.size());

    // Random traffic: noisy bit edges, random stop bits, gaps and glitches.
    for (int r = 0; r < 12; r++) begin
      line.delete();
      add_ones(1);
      for (int f = 0; f < 4; f++) begin
        if ($urandom_range(0, 4) == 0) begin
          line.push_back(1'b0);
          add_ones(2);
        end
        add_frame(8'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
        add_ones($urandom_range(0, 3));
      end
      add_ones(45);
      play();
      $display("random run %0d: pulses=%0d data_out=%02h", r, obs_q.size(), bus.data_out);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
